spike_time_decoder: RTL and testbench
=====================================

SPIKE_TIME_DECODER -- requirements
Module: spike_time_decoder

Interface
REQ-001 The block SHALL have parameter LEN, default 8, meaning spike-vector width in time slots (LEN >= 2).
REQ-002 The block SHALL have derived localparam TW = $clog2(LEN), meaning timestamp width.
REQ-003 The block SHALL have port clock  input  1  meaning sole clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_vec  input  [0:LEN-1]  meaning the spike vector, where bit index i encodes time t = LEN-1-i and multiple set bits form a union of spikes.
REQ-006 The block SHALL have port in_valid  input  1  meaning in_vec is presented.
REQ-007 The block SHALL have port in_ready  output  1  meaning the block accepts in_vec this cycle.
REQ-008 The block SHALL have port out_time  output  TW  meaning the binary timestamp of the current spike.
REQ-009 The block SHALL have port out_valid  output  1  meaning the output beat is valid.
REQ-010 The block SHALL have port out_ready  input  1  meaning the downstream consumer accepts the beat.
REQ-011 The block SHALL have port out_last  output  1  meaning final beat of the current vector.
REQ-012 The block SHALL have port out_empty  output  1  meaning the beat carries no spike because the vector was all-zero.

Function
REQ-013 The block SHALL implement states IDLE, EMIT and NULL.
REQ-014 in_ready SHALL be 1 only in IDLE; an input transfer occurs when in_valid && in_ready.
REQ-015 On transfer in IDLE: in_vec is latched into a pending register; next state is EMIT if in_vec != 0, else NULL.
REQ-016 In EMIT: out_valid=1; out_time = smallest t whose pending bit is set; out_empty=0.
REQ-017 In EMIT: out_last=1 iff exactly one pending bit remains set.
REQ-018 On an EMIT beat with out_ready=1: the emitted bit is cleared; state goes to IDLE if out_last, else stays EMIT.
REQ-019 In NULL: out_valid=1, out_time=0, out_empty=1, out_last=1; on out_ready=1 the next state is IDLE.
REQ-020 While out_valid=1 and out_ready=0, all output ports SHALL hold stable.
REQ-021 Latency: first beat SHALL appear the cycle after input transfer; one beat per cycle under continuous out_ready; one IDLE bubble SHALL separate vectors.
REQ-022 Timestamps SHALL be emitted in strictly ascending order; no spike is dropped or duplicated.
REQ-023 in_vec and in_valid SHALL be ignored outside IDLE.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, pending=0, out_valid=0, out_time=0, out_last=0, out_empty=0, and in_ready=1 from the following cycle.
REQ-025 Reset asserted mid-vector SHALL discard remaining spikes with no further beats; reset takes priority over any simultaneous transfer.

Configuration
REQ-026 With SPIKE_DEC_COUNT_EN defined: add output out_count [$clog2(LEN+1)-1:0] equal to the total spike count of the latched vector, held constant on every beat of that vector (0 on a NULL beat, 0 after reset).
REQ-027 Without SPIKE_DEC_COUNT_EN: out_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package spike_pkg SHALL hold the state enum (IDLE/EMIT/NULL) and a function for slot index <-> time conversion (t = LEN-1-i).
REQ-029 One sub-module spike_prio_find SHALL be combinational and, given the pending vector, return the lowest time t, a one-hot clear mask, and a single-remaining flag.

Verification
REQ-030 LEN=8, in_vec=8'b0000_0010 -> one beat: out_time=1, out_last=1, out_empty=0.
REQ-031 in_vec=8'b0110_0011 -> beats out_time=0,1,5,6 on consecutive cycles; out_last only on 6; out_count=4 when the macro is defined.
REQ-032 in_vec=8'b0000_0000 -> single NULL beat: out_empty=1, out_last=1, out_time=0; in_ready=1 on the next cycle.
REQ-033 in_vec=8'b1111_1111 with out_ready low for 3 cycles after the first beat -> out_time=0 held stable for 3 cycles, then 1..7 follow; 8 beats total; out_count=8.
REQ-034 in_vec=8'b1010_1010 with reset pulsed after the second beat -> no further beats; next vector 8'b0000_0001 -> single beat out_time=0.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg -- shared definitions for the spike time decoder.
//   state_t        : decoder FSM states (IDLE / EMIT / NULL)
//   slot_to_time   : converts a spike-vector slot index i to time t = len-1-i
//   time_to_slot   : inverse conversion, time t to slot index i = len-1-t
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    NULL = 2'd2
  } state_t;

  function automatic int slot_to_time(input int len, input int slot);
    return len - 1 - slot;
  endfunction

  function automatic int time_to_slot(input int len, input int t);
    return len - 1 - t;
  endfunction

endpackage

// File: rtl/spike_prio_find.sv
// spike_prio_find -- combinational search over a pending spike vector.
// Slot index i holds the spike at time t = LEN-1-i, so the earliest spike is
// the set bit with the highest slot index.
// Ports:
//   pending    [0:LEN-1]  spikes still waiting to be emitted
//   first_time [TW-1:0]   smallest time t whose pending bit is set (0 if none)
//   clear_mask [0:LEN-1]  one-hot mask selecting that bit (all-zero if none)
//   single     1          exactly one pending bit is set
module spike_prio_find
  import spike_pkg::*;
#(
  parameter int LEN = 8,
  localparam int TW = $clog2(LEN)
) (
  input  logic [0:LEN-1] pending,
  output logic [TW-1:0]  first_time,
  output logic [0:LEN-1] clear_mask,
  output logic           single
);

  // Scan upward in slot index; the last hit is the highest slot, i.e. the
  // smallest time.
  always_comb begin
    first_time = '0;
    clear_mask = '0;
    for (int i = 0; i < LEN; i++) begin
      if (pending[i]) begin
        first_time    = TW'(slot_to_time(LEN, i));
        clear_mask    = '0;
        clear_mask[i] = 1'b1;
      end
    end
  end

  // Only one bit left when removing the selected bit leaves nothing.
  assign single = (pending != '0) && ((pending & ~clear_mask) == '0);

endmodule

// File: rtl/spike_time_decoder.sv
// spike_time_decoder -- converts a union-of-spikes vector into a stream of
// binary timestamps, earliest spike first, one beat per accepted cycle.
// Optional feature macro: SPIKE_DEC_COUNT_EN adds out_count, the number of
// spikes in the latched vector, held on every beat of that vector.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   in_vec         [0:LEN-1] spike vector, slot i means time LEN-1-i
//   in_valid       in_vec is presented
//   in_ready       decoder is idle and takes in_vec this cycle
//   out_time       [TW-1:0] timestamp of the current beat
//   out_valid      beat is valid
//   out_ready      consumer takes the beat this cycle
//   out_last       final beat of the current vector
//   out_empty      beat stands for an all-zero vector (no spike)
//   out_count      [CW-1:0] spike count of the vector (only with the macro)
//   dbg_state      [1:0] current FSM state (spike_pkg::state_t encoding)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until that edge, and
// the decoder keeps every output stable while out_valid && !out_ready.
module spike_time_decoder
  import spike_pkg::*;
#(
  parameter int LEN = 8,
  localparam int TW = $clog2(LEN),
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [0:LEN-1] in_vec,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [TW-1:0]  out_time,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           out_empty,
`ifdef SPIKE_DEC_COUNT_EN
  output logic [CW-1:0]  out_count,
`endif
  output logic [1:0]     dbg_state
);

  state_t         state;
  logic [0:LEN-1] pending;
  logic [TW-1:0]  first_time;
  logic [0:LEN-1] clear_mask;
  logic           single;

  spike_prio_find #(.LEN(LEN)) u_find (
    .pending    (pending),
    .first_time (first_time),
    .clear_mask (clear_mask),
    .single     (single)
  );

  // Outputs are pure functions of the registered state and pending vector,
  // so they cannot move while the consumer stalls.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign out_time  = (state == EMIT) ? first_time : '0;
  assign out_last  = (state == EMIT) ? single : (state == NULL);
  assign out_empty = (state == NULL);
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= in_vec;
            state   <= (in_vec != '0) ? EMIT : NULL;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pending & ~clear_mask;
            if (single) state <= IDLE;
          end
        end
        NULL: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_DEC_COUNT_EN
  logic [CW-1:0] in_pop;
  logic [CW-1:0] count_q;

  always_comb begin
    in_pop = '0;
    for (int i = 0; i < LEN; i++) in_pop = in_pop + CW'(in_vec[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (state == IDLE && in_valid) begin
      count_q <= in_pop;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_spike_time_decoder.sv
// tb_spike_time_decoder -- randomized self-checking bench for spike_time_decoder.
// A vector is modelled as a plain number whose bit t is a spike at time t;
// expected beats are the set bit positions in ascending order.
module tb_spike_time_decoder;
  localparam int LEN = 8;
  localparam int TW  = $clog2(LEN);
  localparam int CW  = $clog2(LEN + 1);

  logic           clock = 1'b0;
  logic           reset;
  logic [0:LEN-1] in_vec;
  logic           in_valid;
  logic           in_ready;
  logic [TW-1:0]  out_time;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           out_empty;
  logic [1:0]     dbg_state;
`ifdef SPIKE_DEC_COUNT_EN
  logic [CW-1:0]  out_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  spike_time_decoder #(.LEN(LEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_time  (out_time),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_empty (out_empty),
`ifdef SPIKE_DEC_COUNT_EN
    .out_count (out_count),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_time"},  out_time, 0);
    check({tag, "_last"},  out_last, 0);
    check({tag, "_empty"}, out_empty, 0);
  endtask

  // ---------------- driver + scoreboard ----------------
  // Send one vector and consume its beats.
  //   stall_at/stall_len : hold out_ready low for stall_len cycles at that beat
  //   rst_after          : pulse reset once this many beats are taken (<0: never)
  //   rnd_ready          : randomize out_ready on the other cycles
  task automatic do_vec(input logic [LEN-1:0] v, input int stall_at, input int stall_len,
                        input int rst_after, input bit rnd_ready);
    logic [TW-1:0] exp_q[$];
    bit  is_null;
    int  taken, stalls, cyc;
    bit  rdy;

    exp_q = {};
    for (int t = 0; t < LEN; t++) if (v[t]) exp_q.push_back(TW'(t));
    is_null = (v == '0);

    @(negedge clock);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("in_ready_before", in_ready, 1);
    in_vec   = v;          // value bit t lands in slot LEN-1-t
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    taken  = 0;
    stalls = 0;
    cyc    = 0;
    forever begin
      if (rst_after >= 0 && taken == rst_after) begin
        reset    = 1'b1;
        in_valid = 1'b1;                      // must lose to reset
        in_vec   = LEN'($urandom_range(1, (1 << LEN) - 1));
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        check_idle("midreset");
        for (int k = 0; k < 3; k++) begin
          out_ready = 1'(k % 2);
          @(negedge clock);
          check("midreset_no_beat", out_valid, 0);
        end
        out_ready = 1'b0;
        return;
      end
      if (cyc > 200) begin
        check("beat_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      // Inputs outside IDLE must have no effect.
      in_valid = 1'($urandom_range(0, 1));
      in_vec   = LEN'($urandom);
      check("beat_valid", out_valid, 1);
      check("beat_ready_low", in_ready, 0);
      if (is_null) begin
        check("null_empty", out_empty, 1);
        check("null_last",  out_last, 1);
        check("null_time",  out_time, 0);
      end else begin
        check("beat_time",  out_time, exp_q[0]);
        check("beat_last",  out_last, exp_q.size() == 1);
        check("beat_empty", out_empty, 0);
      end
`ifdef SPIKE_DEC_COUNT_EN
      check("beat_count", out_count, $countones(v));
`endif
      if (taken == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      out_ready = rdy;
      if (rdy && (is_null || exp_q.size() == 1)) in_valid = 1'b0;
      @(negedge clock);
      cyc++;
      if (rdy) begin
        taken++;
        if (is_null) break;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) break;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    // One idle bubble between vectors.
    check("bubble_valid", out_valid, 0);
    check("bubble_ready", in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_ready", in_ready, 1);
`ifdef SPIKE_DEC_COUNT_EN
    check("after_reset_count", out_count, 0);
`endif

    do_vec(8'b0000_0010, -1, 0, -1, 0);   // single spike at t=1
    do_vec(8'b0110_0011, -1, 0, -1, 0);   // t = 0,1,5,6 back to back
    do_vec(8'b0000_0000, -1, 0, -1, 0);   // NULL beat
    do_vec(8'b1111_1111,  0, 3, -1, 0);   // first beat stalled 3 cycles
    do_vec(8'b1010_1010, -1, 0,  2, 0);   // reset after second beat
    do_vec(8'b0000_0001, -1, 0, -1, 0);   // single spike at t=0
    do_vec(8'b1000_0000, -1, 0, -1, 1);   // latest slot only

    for (int n = 0; n < 40; n++) begin
      logic [LEN-1:0] rv;
      rv = (n % 8 == 0) ? '0 : LEN'($urandom);
      do_vec(rv, $urandom_range(0, 3), $urandom_range(0, 3),
             (n % 10 == 9) ? int'($urandom_range(0, 2)) : -1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
